// File: rtl/piano_pkg.sv
// Shared piano constants: key/voice defaults, octave width and the note-id encoding
// used by kb2piano_octave, the voice allocator and the display logic.
package piano_pkg;

  localparam int unsigned NUM_KEYS_DEF   = 12;
  localparam int unsigned NUM_VOICES_DEF = 4;
  localparam int unsigned OCT_W_DEF      = 3;
  localparam int unsigned NOTE_W_DEF     = $clog2(NUM_KEYS_DEF + 1);

  localparam logic [NOTE_W_DEF-1:0] NOTE_NONE = '0;

  typedef enum logic [NOTE_W_DEF-1:0] {
    NOTE_OFF = 4'd0,
    NOTE_C   = 4'd1,
    NOTE_CS  = 4'd2,
    NOTE_D   = 4'd3,
    NOTE_DS  = 4'd4,
    NOTE_E   = 4'd5,
    NOTE_F   = 4'd6,
    NOTE_FS  = 4'd7,
    NOTE_G   = 4'd8,
    NOTE_GS  = 4'd9,
    NOTE_A   = 4'd10,
    NOTE_AS  = 4'd11,
    NOTE_B   = 4'd12
  } note_e;

  // True when a note id names a real key (1..num_keys); 0 and overrange ids are not keys.
  function automatic logic is_piano_key(input int unsigned note, input int unsigned num_keys);
    return (note != 0) && (note <= num_keys);
  endfunction

endpackage

// File: rtl/piano_voice_allocator_age_tracker.sv
// Voice age ranks: rank 0 is the newest allocation, rank NUM_VOICES-1 the oldest.
module voice_age_tracker #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned IDX_W      = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic [IDX_W-1:0] target,
  output logic [IDX_W-1:0] oldest_c
);

  logic [IDX_W-1:0] rank_q [NUM_VOICES];
  logic [IDX_W-1:0] rank_n [NUM_VOICES];
  logic [IDX_W-1:0] target_rank;

  always_comb begin
    oldest_c    = '0;
    target_rank = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (rank_q[v] == IDX_W'(NUM_VOICES - 1)) oldest_c = IDX_W'(v);
      if (IDX_W'(v) == target) target_rank = rank_q[v];
    end
  end

  // Younger-than-target voices age by one; the target becomes the newest.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      rank_n[v] = rank_q[v];
      if (alloc) begin
        if (IDX_W'(v) == target)          rank_n[v] = '0;
        else if (rank_q[v] < target_rank) rank_n[v] = rank_q[v] + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= IDX_W'(v);
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) rank_q[v] <= rank_n[v];
    end
  end

endmodule

// File: rtl/piano_voice_allocator.sv
// Polyphonic key tracker: holds the key bitmap and assigns new presses to voices,
// stealing the oldest voice when all are busy.
module piano_voice_allocator
  import piano_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = NUM_KEYS_DEF,
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned NOTE_W     = $clog2(NUM_KEYS + 1),
  parameter int unsigned OCT_W      = OCT_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_valid,
  input  logic                         key_release,
  input  logic [NOTE_W-1:0]            key_note,
  input  logic [OCT_W-1:0]             octave,
  input  logic                         all_off,
  output logic [NUM_KEYS-1:0]          key_status,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES*OCT_W-1:0]  voice_octave,
  output logic [NUM_VOICES-1:0]        voice_start,
  output logic                         voice_steal,
  output logic [7:0]                   steal_count,
  output logic [NOTE_W-1:0]            last_note,
  output logic                         display_update
);

  localparam int unsigned VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic                         note_ok;
  logic                         note_held;
  logic                         free_found;
  logic [VIDX_W-1:0]            free_idx;
  logic [VIDX_W-1:0]            oldest_idx;
  logic [VIDX_W-1:0]            target_idx;
  logic                         make_new;
  logic                         brk;

  logic [NUM_KEYS-1:0]          key_status_n;
  logic [NUM_VOICES-1:0]        voice_active_n;
  logic [NUM_VOICES*NOTE_W-1:0] voice_note_n;
  logic [NUM_VOICES*OCT_W-1:0]  voice_octave_n;
  logic [NUM_VOICES-1:0]        voice_start_n;
  logic                         voice_steal_n;
  logic [7:0]                   steal_count_n;
  logic [NOTE_W-1:0]            last_note_n;
  logic                         display_update_n;

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .IDX_W      (VIDX_W)
  ) u_age (
    .clk      (clk),
    .reset    (reset),
    .alloc    (make_new),
    .target   (target_idx),
    .oldest_c (oldest_idx)
  );

  // Event decode: held lookup, lowest free voice, and the qualified make/break strobes.
  always_comb begin
    note_ok   = is_piano_key(32'(key_note), NUM_KEYS);
    note_held = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_note == NOTE_W'(i + 1)) note_held = key_status[i];
    end
    free_found = 1'b0;
    free_idx   = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!voice_active[v]) begin
        free_found = 1'b1;
        free_idx   = VIDX_W'(v);
      end
    end
    target_idx = free_found ? free_idx : oldest_idx;
    make_new   = key_valid && !all_off && note_ok && !key_release && !note_held;
    brk        = key_valid && !all_off && note_ok &&  key_release &&  note_held;
  end

  always_comb begin
    key_status_n     = key_status;
    voice_active_n   = voice_active;
    voice_note_n     = voice_note;
    voice_octave_n   = voice_octave;
    voice_start_n    = '0;
    voice_steal_n    = 1'b0;
    steal_count_n    = steal_count;
    last_note_n      = last_note;
    display_update_n = 1'b0;

    if (all_off) begin
      key_status_n     = '0;
      voice_active_n   = '0;
      last_note_n      = NOTE_W'(NOTE_NONE);
      display_update_n = (last_note != NOTE_W'(NOTE_NONE));
    end else if (make_new) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_note == NOTE_W'(i + 1)) key_status_n[i] = 1'b1;
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (VIDX_W'(v) == target_idx) begin
          voice_active_n[v]                 = 1'b1;
          voice_note_n[v*NOTE_W +: NOTE_W]  = key_note;
          voice_octave_n[v*OCT_W +: OCT_W]  = octave;
          voice_start_n[v]                  = 1'b1;
        end
      end
      if (!free_found) begin
        voice_steal_n = 1'b1;
        if (steal_count != 8'hFF) steal_count_n = steal_count + 8'd1;
      end
      last_note_n      = key_note;
      display_update_n = (last_note != key_note);
    end else if (brk) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (key_note == NOTE_W'(i + 1)) key_status_n[i] = 1'b0;
      end
      // A stolen note owns no voice, so this may match nothing.
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (voice_active[v] && (voice_note[v*NOTE_W +: NOTE_W] == key_note))
          voice_active_n[v] = 1'b0;
      end
      if (last_note == key_note) begin
        last_note_n      = NOTE_W'(NOTE_NONE);
        display_update_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_status     <= '0;
      voice_active   <= '0;
      voice_note     <= '0;
      voice_octave   <= '0;
      voice_start    <= '0;
      voice_steal    <= 1'b0;
      steal_count    <= '0;
      last_note      <= '0;
      display_update <= 1'b0;
    end else begin
      key_status     <= key_status_n;
      voice_active   <= voice_active_n;
      voice_note     <= voice_note_n;
      voice_octave   <= voice_octave_n;
      voice_start    <= voice_start_n;
      voice_steal    <= voice_steal_n;
      steal_count    <= steal_count_n;
      last_note      <= last_note_n;
      display_update <= display_update_n;
    end
  end

endmodule

// File: tb/tb_piano_voice_allocator.sv
// Directed bench for piano_voice_allocator: a vector table plus hand-written sequences
// for octave latching, release, saturation and asynchronous reset.
module tb_piano_voice_allocator;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_valid;
  logic        key_release;
  logic [3:0]  key_note;
  logic [2:0]  octave;
  logic        all_off;
  logic [11:0] key_status;
  logic [3:0]  voice_active;
  logic [15:0] voice_note;
  logic [11:0] voice_octave;
  logic [3:0]  voice_start;
  logic        voice_steal;
  logic [7:0]  steal_count;
  logic [3:0]  last_note;
  logic        display_update;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piano_voice_allocator dut (
    .clk            (clk),
    .reset          (reset),
    .key_valid      (key_valid),
    .key_release    (key_release),
    .key_note       (key_note),
    .octave         (octave),
    .all_off        (all_off),
    .key_status     (key_status),
    .voice_active   (voice_active),
    .voice_note     (voice_note),
    .voice_octave   (voice_octave),
    .voice_start    (voice_start),
    .voice_steal    (voice_steal),
    .steal_count    (steal_count),
    .last_note      (last_note),
    .display_update (display_update)
  );

  typedef struct {
    logic        kv;
    logic        rel;
    logic [3:0]  note;
    logic        aoff;
    logic [11:0] st;
    logic [3:0]  act;
    logic [3:0]  start;
    logic        steal;
    logic [7:0]  cnt;
    logic [3:0]  last;
    logic        disp;
    logic [15:0] vn;
  } vec_t;

  vec_t tv [18];

  function automatic vec_t mk(input logic kv, input logic rel, input logic [3:0] note,
                              input logic aoff, input logic [11:0] st, input logic [3:0] act,
                              input logic [3:0] start, input logic steal, input logic [7:0] cnt,
                              input logic [3:0] last, input logic disp, input logic [15:0] vn);
    vec_t t;
    t.kv = kv; t.rel = rel; t.note = note; t.aoff = aoff; t.st = st; t.act = act;
    t.start = start; t.steal = steal; t.cnt = cnt; t.last = last; t.disp = disp; t.vn = vn;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Drive one event on the falling edge; sample 1 ns after the capturing rising edge.
  task automatic ev(input logic kv, input logic rel, input logic [3:0] n,
                    input logic [2:0] oct, input logic aoff);
    @(negedge clk);
    key_valid   = kv;
    key_release = rel;
    key_note    = n;
    octave      = oct;
    all_off     = aoff;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    all_off   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_release = 1'b0; key_note = 4'd0;
    octave = 3'd3; all_off = 1'b0;

    //          kv    rel   note  aoff  status    active   start    stl   cnt    last   disp  vnote
    tv[0]  = mk(1'b1, 1'b0, 4'd1, 1'b0, 12'h001, 4'b0001, 4'b0001, 1'b0, 8'd0, 4'd1,  1'b1, 16'h0001);
    tv[1]  = mk(1'b1, 1'b0, 4'd1, 1'b0, 12'h001, 4'b0001, 4'b0000, 1'b0, 8'd0, 4'd1,  1'b0, 16'h0001);
    tv[2]  = mk(1'b1, 1'b0, 4'd3, 1'b0, 12'h005, 4'b0011, 4'b0010, 1'b0, 8'd0, 4'd3,  1'b1, 16'h0031);
    tv[3]  = mk(1'b1, 1'b0, 4'd5, 1'b0, 12'h015, 4'b0111, 4'b0100, 1'b0, 8'd0, 4'd5,  1'b1, 16'h0531);
    tv[4]  = mk(1'b1, 1'b0, 4'd6, 1'b0, 12'h035, 4'b1111, 4'b1000, 1'b0, 8'd0, 4'd6,  1'b1, 16'h6531);
    tv[5]  = mk(1'b1, 1'b0, 4'd8, 1'b0, 12'h0B5, 4'b1111, 4'b0001, 1'b1, 8'd1, 4'd8,  1'b1, 16'h6538);
    tv[6]  = mk(1'b1, 1'b1, 4'd1, 1'b0, 12'h0B4, 4'b1111, 4'b0000, 1'b0, 8'd1, 4'd8,  1'b0, 16'h6538);
    tv[7]  = mk(1'b1, 1'b1, 4'd3, 1'b0, 12'h0B0, 4'b1101, 4'b0000, 1'b0, 8'd1, 4'd8,  1'b0, 16'h6538);
    tv[8]  = mk(1'b1, 1'b0, 4'd0, 1'b0, 12'h0B0, 4'b1101, 4'b0000, 1'b0, 8'd1, 4'd8,  1'b0, 16'h6538);
    tv[9]  = mk(1'b1, 1'b0, 4'd13,1'b0, 12'h0B0, 4'b1101, 4'b0000, 1'b0, 8'd1, 4'd8,  1'b0, 16'h6538);
    tv[10] = mk(1'b1, 1'b0, 4'd10,1'b0, 12'h2B0, 4'b1111, 4'b0010, 1'b0, 8'd1, 4'd10, 1'b1, 16'h65A8);
    tv[11] = mk(1'b1, 1'b0, 4'd12,1'b0, 12'hAB0, 4'b1111, 4'b0100, 1'b1, 8'd2, 4'd12, 1'b1, 16'h6CA8);
    tv[12] = mk(1'b1, 1'b1, 4'd12,1'b0, 12'h2B0, 4'b1011, 4'b0000, 1'b0, 8'd2, 4'd0,  1'b1, 16'h6CA8);
    tv[13] = mk(1'b1, 1'b1, 4'd5, 1'b0, 12'h2A0, 4'b1011, 4'b0000, 1'b0, 8'd2, 4'd0,  1'b0, 16'h6CA8);
    tv[14] = mk(1'b1, 1'b1, 4'd5, 1'b0, 12'h2A0, 4'b1011, 4'b0000, 1'b0, 8'd2, 4'd0,  1'b0, 16'h6CA8);
    tv[15] = mk(1'b1, 1'b0, 4'd7, 1'b1, 12'h000, 4'b0000, 4'b0000, 1'b0, 8'd2, 4'd0,  1'b0, 16'h6CA8);
    tv[16] = mk(1'b1, 1'b0, 4'd2, 1'b0, 12'h002, 4'b0001, 4'b0001, 1'b0, 8'd2, 4'd2,  1'b1, 16'h6CA2);
    tv[17] = mk(1'b0, 1'b0, 4'd0, 1'b1, 12'h000, 4'b0000, 4'b0000, 1'b0, 8'd2, 4'd0,  1'b1, 16'h6CA2);

    #1;
    chk("rst_status", 32'(key_status), 32'h0);
    chk("rst_active", 32'(voice_active), 32'h0);
    chk("rst_count", 32'(steal_count), 32'h0);
    chk("rst_last", 32'(last_note), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      ev(tv[i].kv, tv[i].rel, tv[i].note, 3'd3, tv[i].aoff);
      chk($sformatf("v%0d_status", i), 32'(key_status), 32'(tv[i].st));
      chk($sformatf("v%0d_active", i), 32'(voice_active), 32'(tv[i].act));
      chk($sformatf("v%0d_start", i), 32'(voice_start), 32'(tv[i].start));
      chk($sformatf("v%0d_steal", i), 32'(voice_steal), 32'(tv[i].steal));
      chk($sformatf("v%0d_count", i), 32'(steal_count), 32'(tv[i].cnt));
      chk($sformatf("v%0d_last", i), 32'(last_note), 32'(tv[i].last));
      chk($sformatf("v%0d_disp", i), 32'(display_update), 32'(tv[i].disp));
      chk($sformatf("v%0d_vnote", i), 32'(voice_note), 32'(tv[i].vn));
    end

    // Octave is latched per voice at allocation.
    do_reset();
    ev(1'b1, 1'b0, 4'd1, 3'd4, 1'b0);
    ev(1'b1, 1'b0, 4'd3, 3'd5, 1'b0);
    chk("oct_v0", 32'(voice_octave[2:0]), 32'd4);
    chk("oct_v1", 32'(voice_octave[5:3]), 32'd5);
    ev(1'b1, 1'b1, 4'd3, 3'd6, 1'b0);
    chk("rel_active", 32'(voice_active), 32'b0001);
    chk("rel_last", 32'(last_note), 32'd0);
    chk("rel_disp", 32'(display_update), 32'd1);
    chk("rel_oct_hold", 32'(voice_octave[5:3]), 32'd5);
    ev(1'b1, 1'b1, 4'd1, 3'd6, 1'b0);
    chk("idle_active", 32'(voice_active), 32'd0);
    chk("idle_status", 32'(key_status), 32'd0);
    chk("idle_disp", 32'(display_update), 32'd0);

    // Continuous stealing: allocation k uses note k%12+1, the stolen key is then released.
    do_reset();
    for (int k = 0; k < 4; k++) ev(1'b1, 1'b0, 4'(k % 12 + 1), 3'd1, 1'b0);
    for (int k = 4; k < 260; k++) begin
      ev(1'b1, 1'b0, 4'(k % 12 + 1), 3'd1, 1'b0);
      if (k == 4) chk("sat_first", 32'(steal_count), 32'd1);
      ev(1'b1, 1'b1, 4'((k - 4) % 12 + 1), 3'd1, 1'b0);
    end
    chk("sat_count", 32'(steal_count), 32'd255);
    chk("sat_active", 32'(voice_active), 32'b1111);

    // Reset asserted between clock edges clears outputs immediately.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_status", 32'(key_status), 32'd0);
    chk("async_active", 32'(voice_active), 32'd0);
    chk("async_count", 32'(steal_count), 32'd0);
    chk("async_vnote", 32'(voice_note), 32'd0);
    chk("async_last", 32'(last_note), 32'd0);
    #10 reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
